pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch sequencer for the program counter in the CPU core. It owns the PC register and drives a request/acknowledge handshake to instruction memory. It holds each fetched instruction stable for the execute stage. It selects the next PC from trap, jump, branch or sequential sources with fixed priority. It replaces a bare PC register with a small state machine that tolerates variable-latency instruction memory and downstream stalls.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- RESET_HOLD, 1: cycles (1–15) spent in HOLD after rst deasserts before the first fetch.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  execute stage not ready; freezes EXEC.
- br_taken  in  1  conditional branch taken; sampled in EXEC only.
- br_target  in  32  branch target.
- jmp_valid  in  1  unconditional jump; sampled in EXEC only.
- jmp_target  in  32  jump target.
- trap  in  1  exception/trap request; sampled in EXEC only.
- trap_vec  in  32  trap vector.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  current PC.
- inst  out  32  latched instruction.
- inst_valid  out  1  inst/pc valid for execute.
- misalign  out  1  one-cycle pulse: selected redirect target had nonzero [1:0].
- instret  out  32  retired-instruction count (see Configuration).

## Operation
- States: HOLD, FETCH, EXEC.
- HOLD: pc=RESET_PC, imem_req=0, inst_valid=0. A 4-bit counter counts RESET_HOLD cycles, then the block enters FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata and the block enters EXEC. Without ack, it stays; req and addr stay stable.
- EXEC: inst_valid=1, imem_req=0.
  - stall=1: stay; pc and inst are held.
  - stall=0: pc<=next_pc, the block enters FETCH, and the instruction counts as retired.
- next_pc priority:
  - trap → trap_vec
  - else jmp_valid → jmp_target
  - else br_taken → br_target
  - else pc+4
- The selected target is loaded with bits [1:0] forced to 0.
- misalign pulses for one cycle coincident with the EXEC exit when the raw selected target had [1:0]≠0. pc+4 never raises misalign.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect inputs are ignored outside EXEC and while stall=1.
- imem_ack is ignored in HOLD and EXEC.

## Timing
- Reset values: pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, misalign=0, instret=0, state=HOLD, hold counter=0.
- rst asserted mid-fetch or mid-stall: outputs go to their reset values immediately (asynchronous). A pending ack is discarded.
- First imem_req rises RESET_HOLD cycles after the first rising edge with rst low.
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction (FETCH, EXEC).
- N wait cycles add N cycles per instruction.
- A new pc is visible on imem_addr in the cycle after the EXEC exit.
- inst_valid rises the cycle after ack and falls the cycle after the EXEC exit.

## Configuration
- PC_SEQ_PERF_EN defined: instret is a 32-bit counter.
  - It increments by 1 on each EXEC exit with stall=0.
  - It wraps at 2^32.
  - rst clears it.
- PC_SEQ_PERF_EN undefined: instret is tied to 32'h0 and no counter flops exist.

## Test plan
- Reset/hold: RESET_PC=32'h100, RESET_HOLD=3; release rst → imem_req rises on the 3rd edge after release with imem_addr=32'h100; inst_valid=0 throughout.
- Sequential with waits: ack delayed 2 cycles, rdata=32'hDEADBEEF → inst=32'hDEADBEEF, inst_valid high one cycle later; next imem_addr=32'h104; 4 cycles per instruction.
- Priority: in EXEC, trap=1 (vec 32'h80), jmp_valid=1 (32'h200), br_taken=1 (32'h300) → pc=32'h80; jmp+br only → 32'h200; br only → 32'h300.
- Stall and misalign: stall=1 for 5 cycles with br_target=32'h302 → pc and inst frozen; after stall=0 → pc=32'h300, misalign pulses exactly 1 cycle.
- Wrap/async reset: pc=32'hFFFF_FFFC with no redirect → next pc=32'h0. Assert rst while imem_req=1 → imem_req=0 before the next edge; a later ack is ignored.
- Perf counter: with PC_SEQ_PERF_EN, 10 retirements (including stalled cycles) → instret=10; without the macro → instret=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, handshakes with instruction memory and holds the fetched word for execute.
// Optional retired-instruction counter enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        trap,
    input  logic [31:0] trap_vec,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  hold_cnt;
    logic [31:0] raw_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= 4'd0;
            pc       <= RESET_PC;
            inst     <= 32'h0;
        end else begin
            state <= next_state;
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 4'd1;
            end else begin
                hold_cnt <= 4'd0;
            end
            if (state == FETCH && imem_ack) begin
                inst <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

    // Redirect sources are only meaningful at the EXEC exit; elsewhere they are don't-care.
    always_comb begin
        next_state = state;
        raw_target = pc + 32'd4;
        redirect   = 1'b0;
        if (trap) begin
            raw_target = trap_vec;
            redirect   = 1'b1;
        end else if (jmp_valid) begin
            raw_target = jmp_target;
            redirect   = 1'b1;
        end else if (br_taken) begin
            raw_target = br_target;
            redirect   = 1'b1;
        end
        next_pc = {raw_target[31:2], 2'b00};
        retire  = (state == EXEC) && !stall;

        case (state)
            HOLD:    if (hold_cnt == HOLD_LAST) next_state = FETCH;
            FETCH:   if (imem_ack) next_state = EXEC;
            EXEC:    if (!stall) next_state = FETCH;
            default: next_state = HOLD;
        endcase
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == EXEC);
    assign misalign   = retire && redirect && (raw_target[1:0] != 2'b00);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 32'h0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC=0x100, RESET_HOLD=3).
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        trap;
    logic [31:0] trap_vec;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        misalign;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .RESET_PC  (32'h0000_0100),
        .RESET_HOLD(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_valid (jmp_valid),
        .jmp_target(jmp_target),
        .trap      (trap),
        .trap_vec  (trap_vec),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .pc        (pc),
        .inst      (inst),
        .inst_valid(inst_valid),
        .misalign  (misalign),
        .instret   (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH cycle: wait the given cycles, then ack once; returns in EXEC.
    task automatic fetch_exec(input int waits, input logic [31:0] data);
        imem_ack = 1'b0;
        for (int w = 0; w < waits; w++) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h100); end
        checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected %h", inst, 32'h0); end
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl: got req=%b valid=%b mis=%b expected 0/0/0", imem_req, inst_valid, misalign); end
        checks++; if (instret !== 32'h0) begin errors++; $display("[TB] FAIL reset_instret: got %h expected %h", instret, 32'h0); end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (imem_req !== (k == 3)) begin errors++; $display("[TB] FAIL hold_req_edge%0d: got %b expected %b", k, imem_req, (k == 3)); end
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid_edge%0d: got %b expected 0", k, inst_valid); end
        end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, 32'h100); end
    endtask

    task automatic test_sequential();
        imem_ack = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL wait_hold: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, 32'h100); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (inst !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL seq_inst: got %h expected %h", inst, 32'hDEAD_BEEF); end
        checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_exec: got valid=%b req=%b expected 1/0", inst_valid, imem_req); end
        tick();
        checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_next: got addr=%h req=%b expected %h/1", imem_addr, imem_req, 32'h104); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_fall: got %b expected 0", inst_valid); end
    endtask

    task automatic test_priority();
        fetch_exec(0, 32'h0000_0011);
        trap = 1'b1; trap_vec = 32'h80;
        jmp_valid = 1'b1; jmp_target = 32'h200;
        br_taken = 1'b1; br_target = 32'h300;
        #1;
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL prio_mis: got %b expected 0", misalign); end
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("[TB] FAIL prio_trap: got %h expected %h", pc, 32'h80); end
        trap = 1'b0;
        fetch_exec(0, 32'h0000_0022);
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("[TB] FAIL prio_jmp: got %h expected %h", pc, 32'h200); end
        jmp_valid = 1'b0;
        fetch_exec(0, 32'h0000_0033);
        tick();
        checks++; if (pc !== 32'h300) begin errors++; $display("[TB] FAIL prio_br: got %h expected %h", pc, 32'h300); end
        br_taken = 1'b0;
        trap = 1'b1; trap_vec = 32'h40;
        tick();
        checks++; if (pc !== 32'h300) begin errors++; $display("[TB] FAIL redirect_in_fetch: got %h expected %h", pc, 32'h300); end
        trap = 1'b0;
    endtask

    task automatic test_stall_misalign();
        fetch_exec(1, 32'hCAFE_0001);
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h302;
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++; if (pc !== 32'h300 || inst !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL stall_freeze%0d: got pc=%h inst=%h expected %h/%h", s, pc, inst, 32'h300, 32'hCAFE_0001); end
            checks++; if (misalign !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ctrl%0d: got mis=%b valid=%b expected 0/1", s, misalign, inst_valid); end
            tick();
        end
        imem_ack = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse: got %b expected 1", misalign); end
        tick();
        checks++; if (pc !== 32'h300) begin errors++; $display("[TB] FAIL mis_pc: got %h expected %h", pc, 32'h300); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_end: got %b expected 0", misalign); end
        br_taken = 1'b0;
    endtask

    task automatic test_wrap();
        fetch_exec(0, 32'h0000_0044);
        jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp_valid = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_setup: got %h expected %h", pc, 32'hFFFF_FFFC); end
        fetch_exec(0, 32'h0000_0055);
        #1;
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL wrap_mis: got %b expected 0", misalign); end
        tick();
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got pc=%h addr=%h expected 0", pc, imem_addr); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_count;
        rst = 1'b1;
        #1;
        checks++; if (instret !== 32'h0 || pc !== 32'h100) begin errors++; $display("[TB] FAIL perf_clear: got instret=%h pc=%h expected 0/%h", instret, pc, 32'h100); end
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            fetch_exec(i % 3, 32'h1000 + i);
            if (i % 2 == 1) begin
                stall = 1'b1;
                tick(); tick();
                stall = 1'b0;
            end
            tick();
        end
`ifdef PC_SEQ_PERF_EN
        exp_count = 32'd10;
`else
        exp_count = 32'd0;
`endif
        checks++; if (instret !== exp_count) begin errors++; $display("[TB] FAIL perf_count: got %0d expected %0d", instret, exp_count); end
        checks++; if (pc !== 32'h128) begin errors++; $display("[TB] FAIL perf_pc: got %h expected %h", pc, 32'h128); end
    endtask

    task automatic test_async_reset();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got %b expected 1", imem_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_immediate: got req=%b valid=%b expected 0/0", imem_req, inst_valid); end
        checks++; if (pc !== 32'h100 || inst !== 32'h0 || instret !== 32'h0) begin errors++; $display("[TB] FAIL ar_values: got pc=%h inst=%h instret=%h expected %h/0/0", pc, inst, instret, 32'h100); end
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ar_ack_ignored: got inst=%h valid=%b req=%b expected 0/0/0", inst, inst_valid, imem_req); end
        imem_ack = 1'b0;
        tick(); tick();
        checks++; if (imem_req !== 1'b1 || inst !== 32'h0) begin errors++; $display("[TB] FAIL ar_refetch: got req=%b inst=%h expected 1/0", imem_req, inst); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        br_taken = 1'b0; br_target = 32'h0;
        jmp_valid = 1'b0; jmp_target = 32'h0;
        trap = 1'b0; trap_vec = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_misalign();
        test_wrap();
        test_perf();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
